// File: rtl/struct_table_ctrl.sv
// struct_table_ctrl: default-fill sequencer and two-way round-robin write
// arbiter for a small table of five-field records, with a registered read port.
// Optional feature macro: STRUCT_TABLE_CTRL_ERR_EN (adds err_cnt / err_sticky).
module struct_table_ctrl #(
   parameter  int DEPTH = 4,
   parameter  int W     = 32,
   localparam int IW    = $clog2(DEPTH)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            init_req,
   input  logic [W-1:0]    init_val,
   output logic            init_busy,
   output logic            init_done,
   input  logic            req0_valid,
   output logic            req0_ready,
   input  logic [IW-1:0]   req0_idx,
   input  logic [2:0]      req0_field,
   input  logic [W-1:0]    req0_data,
   input  logic            req1_valid,
   output logic            req1_ready,
   input  logic [IW-1:0]   req1_idx,
   input  logic [2:0]      req1_field,
   input  logic [W-1:0]    req1_data,
   input  logic [IW-1:0]   rd_idx,
   output logic [5*W-1:0]  rd_data
`ifdef STRUCT_TABLE_CTRL_ERR_EN
   ,
   output logic [7:0]      err_cnt,
   output logic            err_sticky
`endif
);

   typedef enum logic [1:0] {IDLE, FILL, DONE} state_t;

   state_t            state, state_nxt;
   logic [IW-1:0]     cnt;
   logic [W-1:0]      fill_val;
   logic              rr_ptr;      // 0: requester 0 favoured, 1: requester 1
   logic [5*W-1:0]    tbl [DEPTH];
   logic              gnt0, gnt1, load;
   logic              wr_en;
   logic [IW-1:0]     wr_idx;
   logic [2:0]        wr_field;
   logic [W-1:0]      wr_data;

   // Next-state, fill start and grant decode; init_req outranks requesters
   always_comb begin
      state_nxt = state;
      gnt0      = 1'b0;
      gnt1      = 1'b0;
      load      = 1'b0;
      init_busy = 1'b0;
      init_done = 1'b0;
      case (state)
         IDLE: begin
            if (init_req) begin
               load      = 1'b1;
               state_nxt = FILL;
            end else if (req0_valid && req1_valid) begin
               gnt0 = ~rr_ptr;
               gnt1 = rr_ptr;
            end else begin
               gnt0 = req0_valid;
               gnt1 = req1_valid;
            end
         end
         FILL: begin
            init_busy = 1'b1;
            if (cnt == IW'(DEPTH - 1)) state_nxt = DONE;
         end
         DONE: begin
            init_done = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign req0_ready = gnt0;
   assign req1_ready = gnt1;
   assign wr_en      = gnt0 | gnt1;
   assign wr_idx     = gnt1 ? req1_idx   : req0_idx;
   assign wr_field   = gnt1 ? req1_field : req0_field;
   assign wr_data    = gnt1 ? req1_data  : req0_data;

   // FSM state, fill counter/value and round-robin pointer
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         cnt      <= '0;
         fill_val <= '0;
         rr_ptr   <= 1'b0;
      end else begin
         state <= state_nxt;
         if (load) begin
            fill_val <= init_val;
            cnt      <= '0;
         end else if (state == FILL) begin
            cnt <= cnt + 1'b1;
         end
         // after a grant the other requester is favoured
         if (wr_en) rr_ptr <= gnt0;
      end
   end

   // Table storage: whole-record fill writes or single-field keyed writes
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tbl <= '{default: '0};
      end else if (state == FILL) begin
         tbl[cnt] <= {5{fill_val}};
      end else if (wr_en) begin
         case (wr_field)
            3'd0:    tbl[wr_idx][4*W +: W] <= wr_data;
            3'd1:    tbl[wr_idx][3*W +: W] <= wr_data;
            3'd2:    tbl[wr_idx][2*W +: W] <= wr_data;
            3'd3:    tbl[wr_idx][1*W +: W] <= wr_data;
            3'd4:    tbl[wr_idx][0*W +: W] <= wr_data;
            default: ;
         endcase
      end
   end

   // Registered read; a same-edge write is not yet visible
   always_ff @(posedge clk or posedge rst) begin
      if (rst) rd_data <= '0;
      else     rd_data <= tbl[rd_idx];
   end

`ifdef STRUCT_TABLE_CTRL_ERR_EN
   // Saturating count and sticky flag of handshaken invalid field selects
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         err_cnt    <= '0;
         err_sticky <= 1'b0;
      end else if (wr_en && (wr_field > 3'd4)) begin
         if (err_cnt != '1) err_cnt <= err_cnt + 8'd1;
         err_sticky <= 1'b1;
      end
   end
`else
   // invalid field selects are handshaken and dropped without trace
`endif

endmodule

// File: tb/tb_struct_table_ctrl.sv
// Scoreboard bench for struct_table_ctrl: a record-level reference model
// predicts handshakes, fill status and read data; read data is queued and
// checked by a separate monitor one clock later.
module tb_struct_table_ctrl;

   localparam int DEPTH = 4;
   localparam int W     = 32;
   localparam int IW    = $clog2(DEPTH);

   logic            clk = 1'b0;
   logic            rst;
   logic            init_req;
   logic [W-1:0]    init_val;
   logic            init_busy, init_done;
   logic            req0_valid, req0_ready;
   logic [IW-1:0]   req0_idx;
   logic [2:0]      req0_field;
   logic [W-1:0]    req0_data;
   logic            req1_valid, req1_ready;
   logic [IW-1:0]   req1_idx;
   logic [2:0]      req1_field;
   logic [W-1:0]    req1_data;
   logic [IW-1:0]   rd_idx;
   logic [5*W-1:0]  rd_data;
`ifdef STRUCT_TABLE_CTRL_ERR_EN
   logic [7:0]      err_cnt;
   logic            err_sticky;
`endif

   struct_table_ctrl #(.DEPTH(DEPTH), .W(W)) dut (
      .clk(clk), .rst(rst),
      .init_req(init_req), .init_val(init_val),
      .init_busy(init_busy), .init_done(init_done),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_idx(req0_idx),
      .req0_field(req0_field), .req0_data(req0_data),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_idx(req1_idx),
      .req1_field(req1_field), .req1_data(req1_data),
      .rd_idx(rd_idx), .rd_data(rd_data)
`ifdef STRUCT_TABLE_CTRL_ERR_EN
      , .err_cnt(err_cnt), .err_sticky(err_sticky)
`endif
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   task automatic check(input string name, input logic [5*W-1:0] act,
                        input logic [5*W-1:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // ---------------- reference model ----------------
   logic [W-1:0] m_tbl [DEPTH][5];   // field order A, BC1.B, BC1.C, BC2.B, BC2.C
   int           fill_left;          // records still to be filled
   bit           done_now;           // this cycle is the completion pulse
   logic [W-1:0] m_fill;
   int           favour;             // requester that wins a tie
   int           m_err;
   bit           m_sticky;
   logic [5*W-1:0] rdq [$];

   function automatic logic [5*W-1:0] pack(input int idx);
      return {m_tbl[idx][0], m_tbl[idx][1], m_tbl[idx][2],
              m_tbl[idx][3], m_tbl[idx][4]};
   endfunction

   task automatic model_reset();
      for (int i = 0; i < DEPTH; i++)
         for (int f = 0; f < 5; f++) m_tbl[i][f] = '0;
      fill_left = 0;
      done_now  = 0;
      m_fill    = '0;
      favour    = 0;
      m_err     = 0;
      m_sticky  = 0;
   endtask

   // model step: mid-cycle, after the driver has settled the inputs
   initial begin : model_step
      bit idle;
      int g, fld, idx;
      logic [W-1:0] dat;
      model_reset();
      forever begin
         @(negedge clk);
         #2;
         if (rst) begin
            model_reset();
            check("busy_in_reset", 160'(init_busy), '0);
            check("done_in_reset", 160'(init_done), '0);
            rdq.push_back('0);
         end else begin
            idle = (fill_left == 0) && !done_now;
            g = -1;
            if (idle && !init_req) begin
               if (req0_valid && req1_valid) g = favour;
               else if (req0_valid)          g = 0;
               else if (req1_valid)          g = 1;
            end
            check("init_busy",  160'(init_busy),  160'(fill_left > 0));
            check("init_done",  160'(init_done),  160'(done_now));
            check("req0_ready", 160'(req0_ready), 160'(g == 0));
            check("req1_ready", 160'(req1_ready), 160'(g == 1));
`ifdef STRUCT_TABLE_CTRL_ERR_EN
            check("err_cnt",    160'(err_cnt),    160'(m_err));
            check("err_sticky", 160'(err_sticky), 160'(m_sticky));
`endif
            rdq.push_back(pack(int'(rd_idx)));
            if (done_now) begin
               done_now = 0;
            end else if (fill_left > 0) begin
               for (int f = 0; f < 5; f++) m_tbl[DEPTH - fill_left][f] = m_fill;
               fill_left--;
               if (fill_left == 0) done_now = 1;
            end else if (init_req) begin
               m_fill    = init_val;
               fill_left = DEPTH;
            end else if (g >= 0) begin
               idx = (g == 0) ? int'(req0_idx)   : int'(req1_idx);
               fld = (g == 0) ? int'(req0_field) : int'(req1_field);
               dat = (g == 0) ? req0_data        : req1_data;
               if (fld < 5) m_tbl[idx][fld] = dat;
               else begin
                  if (m_err < 255) m_err++;
                  m_sticky = 1;
               end
               favour = 1 - g;
            end
         end
      end
   end

   // monitor: read data appears one clock after the index was presented
   initial begin : monitor
      logic [5*W-1:0] exp;
      forever begin
         @(posedge clk);
         #1;
         if (rdq.size() > 0) begin
            exp = rdq.pop_front();
            check("rd_data", rd_data, exp);
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic idle_inputs();
      init_req   = 1'b0;
      req0_valid = 1'b0;
      req1_valid = 1'b0;
   endtask

   task automatic read_all();
      idle_inputs();
      for (int i = 0; i < DEPTH; i++) begin
         rd_idx = IW'(i);
         @(negedge clk);
      end
   endtask

   initial begin : driver
      rst = 1'b1;
      init_val = '0;
      req0_idx = '0; req0_field = '0; req0_data = '0;
      req1_idx = '0; req1_field = '0; req1_data = '0;
      rd_idx = '0;
      idle_inputs();
      repeat (3) @(negedge clk);
      rst = 1'b0;
      read_all();

      // fill with competing requests on the accept cycle; init_req held
      // through FILL and DONE must not retrigger
      init_req = 1'b1; init_val = 32'd10;
      req0_valid = 1'b1; req0_idx = 2'd1; req0_field = 3'd0; req0_data = 32'h55;
      req1_valid = 1'b1; req1_idx = 2'd2; req1_field = 3'd1; req1_data = 32'h66;
      @(negedge clk);
      init_val = 32'd99;
      repeat (DEPTH + 1) @(negedge clk);
      read_all();

      // both requesters valid: grants alternate, requester 0 builds entry 0
      for (int c = 0; c < 10; c++) begin
         req0_valid = 1'b1; req0_idx = 2'd0;
         req0_field = 3'(c / 2); req0_data = 32'(c / 2 + 1);
         req1_valid = 1'b1; req1_idx = 2'd1;
         req1_field = 3'd0; req1_data = 32'(100 + c);
         @(negedge clk);
      end
      read_all();

      // write and read of the same entry in one cycle
      req0_valid = 1'b1; req0_idx = 2'd2; req0_field = 3'd2; req0_data = 32'd7;
      rd_idx = 2'd2;
      @(negedge clk);
      idle_inputs();
      @(negedge clk);
      @(negedge clk);

      // invalid field selects, then enough to saturate the error count
      req0_valid = 1'b1; req0_idx = 2'd0; req0_field = 3'd6; req0_data = $urandom;
      @(negedge clk);
      idle_inputs();
      @(negedge clk);
      for (int c = 0; c < 300; c++) begin
         req0_valid = 1'b1; req0_field = 3'(5 + $urandom_range(0, 2));
         req0_idx = IW'($urandom); req0_data = $urandom;
         req1_valid = 1'($urandom); req1_field = 3'd7;
         req1_idx = IW'($urandom); req1_data = $urandom;
         rd_idx = IW'($urandom);
         @(negedge clk);
      end
      read_all();

      // random traffic with occasional fills
      for (int c = 0; c < 400; c++) begin
         init_req   = ($urandom_range(0, 15) == 0);
         init_val   = $urandom;
         req0_valid = 1'($urandom); req0_idx = IW'($urandom);
         req0_field = 3'($urandom_range(0, 5)); req0_data = $urandom;
         req1_valid = 1'($urandom); req1_idx = IW'($urandom);
         req1_field = 3'($urandom_range(0, 5)); req1_data = $urandom;
         rd_idx     = IW'($urandom);
         @(negedge clk);
      end
      idle_inputs();
      repeat (DEPTH + 3) @(negedge clk);

      // reset during the second fill cycle
      init_req = 1'b1; init_val = $urandom;
      @(negedge clk);
      init_req = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      req0_valid = 1'b1; req0_idx = 2'd3; req0_field = 3'd4; req0_data = 32'hA5;
      req1_valid = 1'b1; req1_idx = 2'd3; req1_field = 3'd3; req1_data = 32'h5A;
      @(negedge clk);
      read_all();
      repeat (DEPTH + 2) @(negedge clk);
      @(negedge clk);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/struct_table_ctrl.md
Name: struct_table_ctrl

Overview:
- Sequencer and arbiter for a small table of structured records. Each record has five W-bit fields: A, BC1.B, BC1.C, BC2.B and BC2.C.
- Performs "default:" style fills, writing one value into every field of every entry.
- Shares the table's single write port between two requesters, who perform keyed field writes.
- Sits between pattern-producing logic and any consumer reading records through a registered read port.

Parameters:
DEPTH, 4, number of records in the table (power of two, >=2)
W, 32, width of each field (int)
IW, $clog2(DEPTH), index width (derived, not overridden)

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
init_req  in  1  start a default fill
init_val  in  W  default value, sampled on the accepted init_req cycle
init_busy  out  1  fill in progress
init_done  out  1  one-cycle pulse after the last fill write
req0_valid  in  1  requester 0 write valid
req0_ready  out  1  requester 0 write accepted
req0_idx  in  IW  requester 0 record index
req0_field  in  3  requester 0 field select: 0=A, 1=BC1.B, 2=BC1.C, 3=BC2.B, 4=BC2.C
req0_data  in  W  requester 0 write data
req1_valid, req1_ready, req1_idx, req1_field, req1_data: same as requester 0, for requester 1
rd_idx  in  IW  read index
rd_data  out  5*W  registered record, packed {A, BC1.B, BC1.C, BC2.B, BC2.C} with A in the MSBs

Behaviour:
- Reset (async):
  - All table fields = 0; rd_data = 0.
  - FSM = IDLE; init_busy = 0; init_done = 0.
  - Fill counter = 0; round-robin pointer favours requester 0.
- FSM states: IDLE, FILL, DONE.
- IDLE:
  - init_req=1 -> latch init_val into a fill register, counter=0, go to FILL. No requester is granted that cycle; init_req beats pending requests.
  - Otherwise, grant at most one valid requester. If both are valid, grant the one favoured by the pointer.
  - readyN = grantN, combinational from validN and state. A handshake is validN & readyN.
  - After any grant, the pointer favours the other requester. With no grant, the pointer holds.
  - A granted write updates the selected field at the next clock edge.
- FILL:
  - Each cycle, write the fill register into all five fields of entry [counter], then counter++.
  - Exactly DEPTH cycles in FILL. On the write to entry DEPTH-1, go to DONE.
  - init_busy = 1 throughout; req*_ready = 0; init_req is ignored.
- DONE:
  - Lasts one cycle: init_done = 1, init_busy = 0, req*_ready = 0. Then go to IDLE.
  - init_req in DONE is ignored.
- Invalid writes:
  - A field select of 5..7 is still handshaken (ready=1 when granted), but the table is unchanged.
  - The pointer still advances.
- Read port:
  - rd_data <= table[rd_idx] each cycle, so read latency is 1.
  - Same-cycle read and write of one entry returns the old value; the new value is visible on the following read.
- Reset mid-fill aborts immediately. The table returns to 0 (not a partial fill), and no init_done is produced.
- The valid/data of a requester that is not granted are not required to hold. The block does not remember them.

Optional Feature:
- Macro: STRUCT_TABLE_CTRL_ERR_EN.
- Defined:
  - Adds output err_cnt [7:0].
  - err_cnt increments once per handshaken write with field select > 4, saturating at 255. Reset value 0.
  - Also adds output err_sticky (1 bit): set on the first such write, cleared only by rst.
- Undefined: both ports are absent, and invalid writes are dropped silently.

Test Plan:
- Reset, then rd_idx=0..3 -> rd_data=0 for each entry, one cycle after each index. init_busy=0, req0_ready=req1_ready=0.
- init_req=1 with init_val=10 in IDLE, both requesters valid in that cycle:
  - No ready asserted that cycle.
  - init_busy=1 for 4 cycles, then init_done=1 for exactly 1 cycle.
  - Every field of every entry reads 32'd10.
- Both requesters valid continuously, addressing different entries with field 0 (A) and fresh data each cycle -> grants alternate 0,1,0,1. Check entry 0 .A=1; BC1={B:2,C:3} via fields 1/2; BC2={B:4,C:5} via fields 3/4. rd_data = {1,2,3,4,5}.
- Same-cycle write (req0: idx 2, field 2, data 7) and rd_idx=2 -> rd_data BC1.C shows the old value, then 7 on the next read.
- Write with field 6 -> table unchanged. With STRUCT_TABLE_CTRL_ERR_EN: err_cnt=1, err_sticky=1; after 300 such writes, err_cnt=255.
- Assert rst during cycle 2 of a FILL -> all entries read 0, no init_done pulse, FSM in IDLE, pointer favours requester 0.
